// File: rtl/load_extend_if.sv
// ---------------------------------------------------------------------------
// load_extend_if
//   Bundles the request, data-bus and writeback signals of load_extend_ctrl.
//   Modports:
//     slave  - view taken by the load controller (receives requests and
//              bus responses, drives bus strobe, writeback and error pulses)
//     master - view taken by the surrounding core / memory model
//   Signals:
//     req_valid/req_ready/req_addr/req_funct3/req_rd : load request handshake
//     mem_req/mem_addr/mem_ack/mem_rdata             : word-aligned bus read
//     wb_valid/wb_rd/wb_data                         : register writeback
//     misalign_err/bus_err                           : one-cycle error pulses
// ---------------------------------------------------------------------------
interface load_extend_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;
    logic        bus_err;

    modport slave (
        input  req_valid, req_addr, req_funct3, req_rd, mem_ack, mem_rdata,
        output req_ready, mem_req, mem_addr, wb_valid, wb_rd, wb_data,
               misalign_err, bus_err
    );

    modport master (
        output req_valid, req_addr, req_funct3, req_rd, mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_addr, wb_valid, wb_rd, wb_data,
               misalign_err, bus_err
    );
endinterface

// File: rtl/load_extend_ctrl.sv
// ---------------------------------------------------------------------------
// load_extend_ctrl
//   Sequences one data-memory load per request: word-aligned bus read, byte /
//   halfword lane select, sign or zero extension to 32 bits, writeback pulse.
//   Misaligned loads and illegal funct3 codes are rejected with misalign_err.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - load_extend_if.slave (request, data bus, writeback, errors)
//   Configuration macro:
//     LOAD_TIMEOUT_EN - when defined, a WAIT lasting TIMEOUT_CYCLES cycles
//                       without mem_ack aborts the load with a bus_err pulse.
//                       Undefined: WAIT lasts until mem_ack, bus_err is 0.
// ---------------------------------------------------------------------------
module load_extend_ctrl
`ifdef LOAD_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255  // 1..65535
)
`endif
(
    input  logic         clk,
    input  logic         rst_n,
    load_extend_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        WB   = 3'd2,
        ERR  = 3'd3,
        TOUT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic        legal;
    logic [31:0] byte_sh, half_sh, ext;

    // Alignment / encoding check on the incoming request.
    always_comb begin
        legal = 1'b0;
        case (bus.req_funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~bus.req_addr[0];
            3'b010:         legal = (bus.req_addr[1:0] == 2'b00);
            default:        legal = 1'b0;
        endcase
    end

    // Lane select and extension of the returning word, using the captured
    // low address bits and funct3; the result is stored at the ack edge.
    assign byte_sh = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    assign half_sh = bus.mem_rdata >> {addr_q[1], 4'b0000};

    always_comb begin
        ext = bus.mem_rdata;
        case (f3_q)
            3'b000:  ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  ext = {{16{half_sh[15]}}, half_sh[15:0]};
            3'b100:  ext = {24'd0, byte_sh[7:0]};
            3'b101:  ext = {16'd0, half_sh[15:0]};
            default: ext = bus.mem_rdata;
        endcase
    end

`ifdef LOAD_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        tout_hit;

    // cnt_q holds the number of WAIT cycles already spent without an ack.
    assign tout_hit = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE)
            cnt_d = 16'd0;
        else if (state_q == WAIT && !bus.mem_ack)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 16'd0;
        else        cnt_q <= cnt_d;
    end
`else
    logic tout_hit;
    assign tout_hit = 1'b0;
`endif

    // Next state and captured-register updates.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    f3_d    = bus.req_funct3;
                    rd_d    = bus.req_rd;
                    state_d = legal ? WAIT : ERR;
                end
            end
            WAIT: begin
                // An ack in the timeout cycle still completes the load.
                if (bus.mem_ack) begin
                    data_d  = ext;
                    state_d = WB;
                end else if (tout_hit) begin
                    state_d = TOUT;
                end
            end
            WB, ERR, TOUT: state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            f3_q    <= 3'd0;
            rd_q    <= 5'd0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    // All outputs decode directly from state and captured registers, so the
    // three pulses are mutually exclusive by construction.
    assign bus.req_ready    = (state_q == IDLE);
    assign bus.mem_req      = (state_q == WAIT);
    assign bus.mem_addr     = {addr_q[31:2], 2'b00};
    assign bus.wb_valid     = (state_q == WB);
    assign bus.wb_rd        = rd_q;
    assign bus.wb_data      = data_q;
    assign bus.misalign_err = (state_q == ERR);
`ifdef LOAD_TIMEOUT_EN
    assign bus.bus_err      = (state_q == TOUT);
`else
    assign bus.bus_err      = 1'b0;
`endif

endmodule
